// File: rtl/trap_csr_sequencer.sv
// ---------------------------------------------------------------------------
// trap_csr_sequencer
//
// Purpose:
//   Owns the register file's single CSR write port. It accepts one request at
//   a time from decode/execute: a CSR-instruction write, ECALL, EBREAK or MRET.
//   Trap entry writes mepc, then mcause, then redirects fetch to mtvec. MRET
//   redirects fetch to mepc. The core is stalled (busy) while a sequence runs.
//   Every output is registered.
//
// Optional feature (macro MSTATUS_TRAP_EN):
//   When defined, an extra W_MSTATUS cycle updates mstatus (MIE/MPIE/MPP)
//   just before the REDIRECT cycle, for both trap entry and MRET. When
//   undefined, mstatus_in is ignored and W_MSTATUS is never entered.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous reset, active low
//   req_valid      in   request present, held until accepted
//   req_ready      out  high only in IDLE
//   req_kind       in   0=CSR write, 1=ECALL, 2=EBREAK, 3=MRET
//   req_pc         in   PC of the requesting instruction
//   req_csr_addr   in   target CSR for a CSR write
//   req_csr_wdata  in   data for a CSR write
//   mtvec_in       in   current mtvec from the register file
//   mepc_in        in   current mepc from the register file
//   mstatus_in     in   current mstatus (feature build only)
//   csr_we         out  CSR write enable
//   csr_addr       out  CSR write address
//   csr_wdata      out  CSR write data
//   redirect_valid out  one-cycle pulse, fetch loads redirect_pc
//   redirect_pc    out  new fetch PC, holds its last value
//   busy           out  high whenever the state is not IDLE
//   trap_count     out  saturating count of accepted ECALL/EBREAK
// ---------------------------------------------------------------------------
module trap_csr_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_kind,
  input  logic [DATA_WIDTH-1:0]     req_pc,
  input  logic [CSR_ADDR_WIDTH-1:0] req_csr_addr,
  input  logic [DATA_WIDTH-1:0]     req_csr_wdata,
  input  logic [DATA_WIDTH-1:0]     mtvec_in,
  input  logic [DATA_WIDTH-1:0]     mepc_in,
  input  logic [DATA_WIDTH-1:0]     mstatus_in,
  output logic                      csr_we,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      trap_count
);

  localparam logic [1:0] KIND_CSR    = 2'd0;
  localparam logic [1:0] KIND_ECALL  = 2'd1;
  localparam logic [1:0] KIND_EBREAK = 2'd2;
  localparam logic [1:0] KIND_MRET   = 2'd3;

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL  = DATA_WIDTH'(32'h0000_000B);
  localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK = DATA_WIDTH'(32'h0000_0003);

  typedef enum logic [2:0] {
    IDLE,
    W_CSR,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    REDIRECT
  } state_t;

  state_t     state;
  logic [1:0] lat_kind;

  // mtvec is treated as direct mode only: the low two mode bits are dropped.
  logic [DATA_WIDTH-1:0] trap_target;
  logic [DATA_WIDTH-1:0] cause_value;

  assign trap_target = {mtvec_in[DATA_WIDTH-1:2], 2'b00};
  assign cause_value = (lat_kind == KIND_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;

`ifdef MSTATUS_TRAP_EN
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP stays M-mode (only M-mode exists).
  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^mtvec_in[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{mstatus_in, mtvec_in[1:0]};
`endif

  // Single sequencing process. Outputs are registered together with the
  // state they belong to, so each state's CSR write or redirect is visible
  // during the cycle the state is held. Pulsed outputs default to 0 and are
  // only raised on the transition into the state that owns them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lat_kind       <= KIND_CSR;
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
      req_ready      <= 1'b1;
      trap_count     <= '0;
    end else begin
      csr_we         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_kind  <= req_kind;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            case (req_kind)
              KIND_CSR: begin
                state     <= W_CSR;
                csr_we    <= 1'b1;
                csr_addr  <= req_csr_addr;
                csr_wdata <= req_csr_wdata;
              end
              KIND_ECALL, KIND_EBREAK: begin
                state     <= W_MEPC;
                csr_we    <= 1'b1;
                csr_addr  <= ADDR_MEPC;
                csr_wdata <= req_pc;
                if (trap_count != {CNT_WIDTH{1'b1}}) begin
                  trap_count <= trap_count + CNT_WIDTH'(1);
                end
              end
              default: begin
`ifdef MSTATUS_TRAP_EN
                state     <= W_MSTATUS;
                csr_we    <= 1'b1;
                csr_addr  <= ADDR_MSTATUS;
                csr_wdata <= mret_mstatus(mstatus_in);
`else
                state          <= REDIRECT;
                redirect_valid <= 1'b1;
                redirect_pc    <= mepc_in;
`endif
              end
            endcase
          end
        end

        W_CSR: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        W_MEPC: begin
          state     <= W_MCAUSE;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MCAUSE;
          csr_wdata <= cause_value;
        end

        // mtvec_in is sampled here, after the mepc write has landed.
        W_MCAUSE: begin
`ifdef MSTATUS_TRAP_EN
          state     <= W_MSTATUS;
          csr_we    <= 1'b1;
          csr_addr  <= ADDR_MSTATUS;
          csr_wdata <= trap_mstatus(mstatus_in);
`else
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
`endif
        end

        W_MSTATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= (lat_kind == KIND_MRET) ? mepc_in : trap_target;
        end

        REDIRECT: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_csr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_csr_sequencer
//
// Self-checking bench for trap_csr_sequencer. Each test task pushes the CSR
// writes / redirects it expects (with the cycle they must appear in) into a
// queue while driving stimulus; a negedge monitor records what the DUT
// actually produced, and the task pops and compares both queues. The counter
// width is reduced to 2 bits so saturation is reachable. Works with and
// without MSTATUS_TRAP_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trap_csr_sequencer;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = 2;
`ifdef MSTATUS_TRAP_EN
  localparam int FEAT = 1;
`else
  localparam int FEAT = 0;
`endif

  typedef struct {
    logic          we;
    logic          rv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_kind = 2'd0;
  logic [DW-1:0] req_pc = '0;
  logic [AW-1:0] req_csr_addr = '0;
  logic [DW-1:0] req_csr_wdata = '0;
  logic [DW-1:0] mtvec_in = 32'h8000_0101;
  logic [DW-1:0] mepc_in = 32'h8000_0014;
  logic [DW-1:0] mstatus_in = 32'h0000_1880;
  logic          csr_we;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          busy;
  logic [CW-1:0] trap_count;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  trap_csr_sequencer #(
    .DATA_WIDTH(DW),
    .CSR_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_kind(req_kind),
    .req_pc(req_pc),
    .req_csr_addr(req_csr_addr),
    .req_csr_wdata(req_csr_wdata),
    .mtvec_in(mtvec_in),
    .mepc_in(mepc_in),
    .mstatus_in(mstatus_in),
    .csr_we(csr_we),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .busy(busy),
    .trap_count(trap_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every cycle in which the DUT writes a CSR or redirects fetch.
  always @(negedge clock) begin
    if (csr_we || redirect_valid)
      obs_q.push_back(ev_t'{csr_we, redirect_valid, csr_addr,
                            csr_we ? csr_wdata : redirect_pc, cyc});
  end

  // Called at a negedge: present a request and return at the negedge right
  // after the accepting edge. req_valid is left high for the caller.
  task automatic applyStimulus(input logic [1:0] kind, input logic [DW-1:0] pc,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget;
    budget        = 0;
    req_kind      = kind;
    req_pc        = pc;
    req_csr_addr  = a;
    req_csr_wdata = d;
    req_valid     = 1'b1;
    while (req_ready !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (budget >= 50) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: req_ready=%b, required 1 within 50 cycles", req_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b, required 1", req_ready); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    tests_run++;
    if (csr_we !== 1'b0 || redirect_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pulses: we=%b rv=%b, required 0 0", csr_we, redirect_valid); end
    tests_run++;
    if (trap_count !== 2'd0 || redirect_pc !== 32'd0 || csr_addr !== 12'd0) begin
      tests_failed++; $display("[TB] FAIL reset_regs: count=%0d pc=%h addr=%h, required 0 0 0", trap_count, redirect_pc, csr_addr);
    end
    @(negedge clock);
  endtask

  task automatic test_csr_write();
    ev_t e, o;
    int acc;
    acc = cyc + 1;
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h305, 32'h8000_0100, acc});
    applyStimulus(2'd0, 32'h0, 12'h305, 32'h8000_0100);
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL csr_busy: busy=%b ready=%b, required 1 0", busy, req_ready); end
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || csr_we !== 1'b0 || csr_addr !== 12'd0) begin
      tests_failed++; $display("[TB] FAIL csr_idle: busy=%b ready=%b we=%b addr=%h, required 0 1 0 0", busy, req_ready, csr_we, csr_addr);
    end
    repeat (2) @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL csr_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL csr_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL csr_extra: %0d unexpected events, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_ecall();
    ev_t e, o;
    int acc;
    acc = cyc + 1;
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h341, 32'h8000_0010, acc});
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h342, 32'h0000_000B, acc + 1});
    if (FEAT == 1) exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h300, 32'h0000_1800, acc + 2});
    exp_q.push_back(ev_t'{1'b0, 1'b1, 12'h000, 32'h8000_0100, acc + 2 + FEAT});
    applyStimulus(2'd1, 32'h8000_0010, 12'h0, 32'h0);
    req_valid = 1'b0;
    repeat (4 + FEAT) @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL ecall_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL ecall_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL ecall_extra: %0d unexpected events, required 0", obs_q.size()); obs_q.delete(); end
    tests_run++;
    if (trap_count !== 2'd1) begin tests_failed++; $display("[TB] FAIL ecall_count: got %0d, required 1", trap_count); end
    tests_run++;
    if (redirect_pc !== 32'h8000_0100) begin tests_failed++; $display("[TB] FAIL ecall_pc_hold: got %h, required 80000100", redirect_pc); end
  endtask

  task automatic test_mret();
    ev_t e, o;
    int acc;
    acc = cyc + 1;
    if (FEAT == 1) exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h300, 32'h0000_1888, acc});
    exp_q.push_back(ev_t'{1'b0, 1'b1, 12'h000, 32'h8000_0014, acc + FEAT});
    applyStimulus(2'd3, 32'h8000_0040, 12'h0, 32'h0);
    req_valid = 1'b0;
    repeat (2 + FEAT) @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL mret_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL mret_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL mret_extra: %0d unexpected events, required 0", obs_q.size()); obs_q.delete(); end
    tests_run++;
    if (trap_count !== 2'd1) begin tests_failed++; $display("[TB] FAIL mret_count: got %0d, required 1", trap_count); end
  endtask

  // EBREAK followed by a CSR write with req_valid held high; the request
  // fields change while busy and must not disturb the running sequence.
  task automatic test_back_to_back();
    ev_t e, o;
    int acc;
    int len;
    len = 3 + FEAT;
    acc = cyc + 1;
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h341, 32'h8000_0020, acc});
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h342, 32'h0000_0003, acc + 1});
    if (FEAT == 1) exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h300, 32'h0000_1800, acc + 2});
    exp_q.push_back(ev_t'{1'b0, 1'b1, 12'h000, 32'h8000_0100, acc + 2 + FEAT});
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h340, 32'h1234_5678, acc + len + 1});
    applyStimulus(2'd2, 32'h8000_0020, 12'h0, 32'h0);
    req_kind      = 2'd0;
    req_pc        = 32'hDEAD_BEEC;
    req_csr_addr  = 12'h340;
    req_csr_wdata = 32'h1234_5678;
    for (int i = 0; i < len; i++) begin
      tests_run++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL holdoff_%0d: ready=%b busy=%b, required 0 1", i, req_ready, busy); end
      @(negedge clock);
    end
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: ready=%b busy=%b, required 1 0", req_ready, busy); end
    @(negedge clock);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL b2b_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL b2b_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b_extra: %0d unexpected events, required 0", obs_q.size()); obs_q.delete(); end
    tests_run++;
    if (trap_count !== 2'd2) begin tests_failed++; $display("[TB] FAIL b2b_count: got %0d, required 2", trap_count); end
  endtask

  // Two more ECALLs on a 2-bit counter: 2 -> 3, then it must stay at 3.
  task automatic test_saturation();
    ev_t e, o;
    int acc;
    for (int k = 0; k < 2; k++) begin
      acc = cyc + 1;
      exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h341, 32'h8000_0100 + k, acc});
      exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h342, 32'h0000_000B, acc + 1});
      if (FEAT == 1) exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h300, 32'h0000_1800, acc + 2});
      exp_q.push_back(ev_t'{1'b0, 1'b1, 12'h000, 32'h8000_0100, acc + 2 + FEAT});
      applyStimulus(2'd1, 32'h8000_0100 + k, 12'h0, 32'h0);
      req_valid = 1'b0;
      repeat (4 + FEAT) @(negedge clock);
      tests_run++;
      if (trap_count !== 2'd3) begin tests_failed++; $display("[TB] FAIL sat_count_%0d: got %0d, required 3", k, trap_count); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL sat_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL sat_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL sat_extra: %0d unexpected events, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // Reset dropped while mcause is being written: everything clears at once
  // and the pending redirect never happens.
  task automatic test_abort();
    ev_t e, o;
    int acc;
    acc = cyc + 1;
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h341, 32'h8000_0030, acc});
    exp_q.push_back(ev_t'{1'b1, 1'b0, 12'h342, 32'h0000_000B, acc + 1});
    applyStimulus(2'd1, 32'h8000_0030, 12'h0, 32'h0);
    req_valid = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (csr_we !== 1'b0 || csr_addr !== 12'd0 || csr_wdata !== 32'd0 || redirect_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort_outputs: we=%b addr=%h data=%h rv=%b, required all 0", csr_we, csr_addr, csr_wdata, redirect_valid);
    end
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || trap_count !== 2'd0 || redirect_pc !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL abort_state: busy=%b ready=%b count=%0d pc=%h, required 0 1 0 0", busy, req_ready, trap_count, redirect_pc);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin tests_failed++; $display("[TB] FAIL abort_event: missing event, required addr=%h data=%h cyc=%0d", e.addr, e.data, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.rv !== e.rv || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
          tests_failed++; $display("[TB] FAIL abort_event: got we=%b rv=%b addr=%h data=%h cyc=%0d, required we=%b rv=%b addr=%h data=%h cyc=%0d", o.we, o.rv, o.addr, o.data, o.cyc, e.we, e.rv, e.addr, e.data, e.cyc);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL abort_extra: %0d unexpected events after abort, required 0", obs_q.size()); obs_q.delete(); end
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_idle: busy=%b ready=%b, required 0 1", busy, req_ready); end
  endtask

  initial begin
    test_reset();
    test_csr_write();
    test_ecall();
    test_mret();
    test_back_to_back();
    test_saturation();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
